// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
// Load-width encodings, register-zero index and the HALT opcode.
package mips_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_ALT  = 2'b10,
        WIDTH_WORD = 2'b11
    } mem_width_e;

    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam logic [31:0] HALT_INSTR = 32'hffffffff;

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/halfword out of an aligned word and extends it.
// Shared by write-back and the debug memory reader.
module load_extender
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [1:0]            width,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] value
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        byte_fill;
    logic        half_fill;

    assign byte_val  = word[8*offset +: 8];
    assign half_val  = offset[1] ? word[31:16] : word[15:0];
    assign byte_fill = ~is_unsigned & byte_val[7];
    assign half_fill = ~is_unsigned & half_val[15];

    // 2'b10 falls through to the full-word path.
    always_comb begin
        value = word;
        case (width)
            WIDTH_BYTE: value = {{(DATA_WIDTH-8){byte_fill}}, byte_val};
            WIDTH_HALF: value = {{(DATA_WIDTH-16){half_fill}}, half_val};
            default:    value = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register and write-back datapath: load extension, result select,
// HALT tracking and retired count (counter built only with WB_RETIRE_CNT_EN).
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_halt,
    input  logic                  i_valid_MEM,
    input  logic                  i_halt_instr_MEM,
    input  logic                  i_ctl_WB_mem_to_reg_MEM,
    input  logic                  i_ctl_WB_reg_write_MEM,
    input  logic                  i_ctl_MEM_unsigned_MEM,
    input  logic [1:0]            i_ctl_MEM_data_width_MEM,
    input  logic [1:0]            i_byte_offset_MEM,
    input  logic [DATA_WIDTH-1:0] i_mem_data_MEM,
    input  logic [DATA_WIDTH-1:0] i_alu_result_MEM,
    input  logic [ADDR_WIDTH-1:0] i_write_reg_MEM,
    output logic                  o_ctl_wb_reg_write_wb,
    output logic [ADDR_WIDTH-1:0] o_write_addr_wb,
    output logic [DATA_WIDTH-1:0] o_write_data_wb,
    output logic                  o_program_done,
    output logic [CNT_WIDTH-1:0]  o_retired_count
);

    logic                  wb_valid;
    logic                  wb_halt_instr;
    logic                  wb_mem_to_reg;
    logic                  wb_reg_write;
    logic                  wb_unsigned;
    logic [1:0]            wb_width;
    logic [1:0]            wb_offset;
    logic [DATA_WIDTH-1:0] wb_mem_data;
    logic [DATA_WIDTH-1:0] wb_alu_result;
    logic [ADDR_WIDTH-1:0] wb_write_reg;
    logic                  done;
    logic                  retire;
    logic [DATA_WIDTH-1:0] load_value;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb_valid      <= 1'b0;
            wb_halt_instr <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_unsigned   <= 1'b0;
            wb_width      <= 2'b00;
            wb_offset     <= 2'b00;
            wb_mem_data   <= '0;
            wb_alu_result <= '0;
            wb_write_reg  <= '0;
        end else if (!i_halt && !done) begin
            wb_valid      <= i_valid_MEM;
            wb_halt_instr <= i_halt_instr_MEM;
            wb_mem_to_reg <= i_ctl_WB_mem_to_reg_MEM;
            wb_reg_write  <= i_ctl_WB_reg_write_MEM;
            wb_unsigned   <= i_ctl_MEM_unsigned_MEM;
            wb_width      <= i_ctl_MEM_data_width_MEM;
            wb_offset     <= i_byte_offset_MEM;
            wb_mem_data   <= i_mem_data_MEM;
            wb_alu_result <= i_alu_result_MEM;
            wb_write_reg  <= i_write_reg_MEM;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            done <= 1'b0;
        end else if (!i_halt && wb_valid && wb_halt_instr) begin
            done <= 1'b1;
        end
    end

    // A stalled instruction behind HALT never retires.
    assign retire = wb_valid & ~wb_halt_instr & ~done;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (!i_halt && retire && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign o_retired_count = count;
`else
    assign o_retired_count = '0;
`endif

    load_extender #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extender (
        .word        (wb_mem_data),
        .offset      (wb_offset),
        .width       (wb_width),
        .is_unsigned (wb_unsigned),
        .value       (load_value)
    );

    assign o_ctl_wb_reg_write_wb = wb_reg_write & retire & ~i_halt
                                 & (wb_write_reg != ADDR_WIDTH'(REG_ZERO));
    assign o_write_addr_wb = wb_write_reg;
    assign o_write_data_wb = wb_mem_to_reg ? wb_alu_result : load_value;
    assign o_program_done  = done;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized + directed bench for writeback_stage against a behavioural model.
module tb_writeback_stage;

    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_halt;
    logic        i_valid_MEM;
    logic        i_halt_instr_MEM;
    logic        i_ctl_WB_mem_to_reg_MEM;
    logic        i_ctl_WB_reg_write_MEM;
    logic        i_ctl_MEM_unsigned_MEM;
    logic [1:0]  i_ctl_MEM_data_width_MEM;
    logic [1:0]  i_byte_offset_MEM;
    logic [31:0] i_mem_data_MEM;
    logic [31:0] i_alu_result_MEM;
    logic [4:0]  i_write_reg_MEM;
    logic        o_ctl_wb_reg_write_wb;
    logic [4:0]  o_write_addr_wb;
    logic [31:0] o_write_data_wb;
    logic        o_program_done;
    logic [CW-1:0] o_retired_count;

    writeback_stage #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(CW)
    ) dut (
        .i_clk                    (i_clk),
        .i_reset                  (i_reset),
        .i_halt                   (i_halt),
        .i_valid_MEM              (i_valid_MEM),
        .i_halt_instr_MEM         (i_halt_instr_MEM),
        .i_ctl_WB_mem_to_reg_MEM  (i_ctl_WB_mem_to_reg_MEM),
        .i_ctl_WB_reg_write_MEM   (i_ctl_WB_reg_write_MEM),
        .i_ctl_MEM_unsigned_MEM   (i_ctl_MEM_unsigned_MEM),
        .i_ctl_MEM_data_width_MEM (i_ctl_MEM_data_width_MEM),
        .i_byte_offset_MEM        (i_byte_offset_MEM),
        .i_mem_data_MEM           (i_mem_data_MEM),
        .i_alu_result_MEM         (i_alu_result_MEM),
        .i_write_reg_MEM          (i_write_reg_MEM),
        .o_ctl_wb_reg_write_wb    (o_ctl_wb_reg_write_wb),
        .o_write_addr_wb          (o_write_addr_wb),
        .o_write_data_wb          (o_write_data_wb),
        .o_program_done           (o_program_done),
        .o_retired_count          (o_retired_count)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 0;

    // Model: the instruction sitting in write-back, plus done flag and count.
    bit          m_valid, m_hi, m_m2r, m_rw, m_uns, m_done;
    bit [1:0]    m_w, m_off;
    bit [31:0]   m_mem, m_alu;
    bit [4:0]    m_rd;
    int          m_cnt;

    function automatic int cexp(int n);
`ifdef WB_RETIRE_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic bit [31:0] ext(bit [31:0] wd, int off, int w,
                                      bit uns);
        bit [31:0] v;
        if (w == 0) begin
            v = (wd >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (w == 1) begin
            v = (wd >> (off >= 2 ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = wd;
        end
        return v;
    endfunction

    function automatic bit exp_en();
        return m_rw && m_valid && !m_hi && m_rd != 0 && !i_halt && !m_done;
    endfunction

    function automatic bit [31:0] exp_data();
        return m_m2r ? m_alu : ext(m_mem, m_off, m_w, m_uns);
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_hi = 0; m_m2r = 0; m_rw = 0; m_uns = 0;
        m_w = 0; m_off = 0; m_mem = 0; m_alu = 0; m_rd = 0;
        m_done = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit nd;
        nd = m_done;
        if (!i_halt) begin
            if (m_valid && !m_hi && !m_done && m_cnt < CMAX) m_cnt++;
            if (m_valid && m_hi) nd = 1;
            if (!m_done) begin
                m_valid = i_valid_MEM;
                m_hi    = i_halt_instr_MEM;
                m_m2r   = i_ctl_WB_mem_to_reg_MEM;
                m_rw    = i_ctl_WB_reg_write_MEM;
                m_uns   = i_ctl_MEM_unsigned_MEM;
                m_w     = i_ctl_MEM_data_width_MEM;
                m_off   = i_byte_offset_MEM;
                m_mem   = i_mem_data_MEM;
                m_alu   = i_alu_result_MEM;
                m_rd    = i_write_reg_MEM;
            end
            m_done = nd;
        end
    endtask

    always @(negedge i_clk) begin
        if (started && !i_reset) begin
            check("en", o_ctl_wb_reg_write_wb, exp_en());
            check("addr", o_write_addr_wb, m_rd);
            check("data", o_write_data_wb, exp_data());
            check("done", o_program_done, m_done);
            check("count", o_retired_count, cexp(m_cnt));
        end
    end

    task automatic step();
        @(posedge i_clk);
        if (!i_reset) model_edge();
        #2;
    endtask

    task automatic drive(bit v, bit hi, bit m2r, bit rw, bit uns,
                         bit [1:0] w, bit [1:0] off, bit [31:0] mem,
                         bit [31:0] alu, bit [4:0] rd);
        i_valid_MEM = v;
        i_halt_instr_MEM = hi;
        i_ctl_WB_mem_to_reg_MEM = m2r;
        i_ctl_WB_reg_write_MEM = rw;
        i_ctl_MEM_unsigned_MEM = uns;
        i_ctl_MEM_data_width_MEM = w;
        i_byte_offset_MEM = off;
        i_mem_data_MEM = mem;
        i_alu_result_MEM = alu;
        i_write_reg_MEM = rd;
    endtask

    task automatic issue(bit v, bit hi, bit m2r, bit rw, bit uns,
                         bit [1:0] w, bit [1:0] off, bit [31:0] mem,
                         bit [31:0] alu, bit [4:0] rd);
        drive(v, hi, m2r, rw, uns, w, off, mem, alu, rd);
        step();
    endtask

    task automatic async_reset(string tag);
        #1 i_reset = 1;
        model_clear();
        #1;
        check({tag, "_en"}, o_ctl_wb_reg_write_wb, 0);
        check({tag, "_addr"}, o_write_addr_wb, 0);
        check({tag, "_data"}, o_write_data_wb, 0);
        check({tag, "_done"}, o_program_done, 0);
        check({tag, "_cnt"}, o_retired_count, 0);
        @(posedge i_clk);
        #2 i_reset = 0;
    endtask

    task automatic rand_issue();
        bit [4:0] rd;
        rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0,
              1'($urandom), $urandom_range(0, 9) < 7, 1'($urandom),
              2'($urandom), 2'($urandom), $urandom, $urandom, rd);
        i_halt = $urandom_range(0, 9) == 0;
        step();
    endtask

    initial begin
        i_reset = 1;
        i_halt  = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #12;
        check("rst_en", o_ctl_wb_reg_write_wb, 0);
        check("rst_data", o_write_data_wb, 0);
        check("rst_done", o_program_done, 0);
        check("rst_cnt", o_retired_count, 0);
        @(posedge i_clk);
        #2 i_reset = 0;
        started = 1;

        // LB / LBU at offset 3
        issue(1, 0, 0, 1, 0, 2'b00, 2'd3, 32'h80FF_1234, 0, 5'd3);
        check("lb_data", o_write_data_wb, 32'hFFFF_FF80);
        check("lb_en", o_ctl_wb_reg_write_wb, 1);
        issue(1, 0, 0, 1, 1, 2'b00, 2'd3, 32'h80FF_1234, 0, 5'd3);
        check("lbu_data", o_write_data_wb, 32'h0000_0080);
        // LH at offsets 2 and 0
        issue(1, 0, 0, 1, 0, 2'b01, 2'd2, 32'h8001_7FFF, 0, 5'd4);
        check("lh2_data", o_write_data_wb, 32'hFFFF_8001);
        issue(1, 0, 0, 1, 0, 2'b01, 2'd0, 32'h8001_7FFF, 0, 5'd4);
        check("lh0_data", o_write_data_wb, 32'h0000_7FFF);
        // ADD to r0, then bubble
        issue(1, 0, 1, 1, 0, 2'b11, 2'd0, 0, 32'h1234, 5'd0);
        check("r0_en", o_ctl_wb_reg_write_wb, 0);
        issue(0, 0, 1, 1, 0, 2'b11, 2'd0, 0, 32'h55, 5'd9);
        check("bub_en", o_ctl_wb_reg_write_wb, 0);
        check("cnt5", o_retired_count, cexp(5));
        issue(0, 0, 1, 1, 0, 2'b11, 2'd0, 0, 32'h56, 5'd9);
        check("bub_cnt", o_retired_count, cexp(5));

        // Freeze for 3 cycles with a write pending
        issue(1, 0, 1, 1, 0, 2'b11, 2'd0, 0, 32'hAAAA, 5'd7);
        check("pre_en", o_ctl_wb_reg_write_wb, 1);
        drive(1, 0, 1, 1, 0, 2'b11, 2'd0, 0, 32'hBBBB, 5'd8);
        i_halt = 1;
        #1 check("frz_en0", o_ctl_wb_reg_write_wb, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_addr", o_write_addr_wb, 7);
            check("frz_cnt", o_retired_count, cexp(5));
        end
        i_halt = 0;
        #1 check("rel_en", o_ctl_wb_reg_write_wb, 1);
        check("rel_data", o_write_data_wb, 32'hAAAA);
        step();
        check("next_addr", o_write_addr_wb, 8);
        check("cnt6", o_retired_count, cexp(6));

        // HALT then ADDI r5
        issue(1, 1, 1, 0, 0, 2'b11, 2'd0, 0, 32'hFFFF_FFFF, 5'd0);
        check("halt_done0", o_program_done, 0);
        check("cnt7", o_retired_count, cexp(7));
        issue(1, 0, 1, 1, 0, 2'b11, 2'd0, 0, 32'd5, 5'd5);
        check("halt_done1", o_program_done, 1);
        check("r5_en", o_ctl_wb_reg_write_wb, 0);
        for (int i = 0; i < 3; i++)
            issue(1, 0, 1, 1, 0, 2'b11, 2'd0, 0, 32'd6, 5'd6);
        check("post_en", o_ctl_wb_reg_write_wb, 0);
        check("post_cnt", o_retired_count, cexp(7));

        async_reset("rst_done");

        // Saturation: many back-to-back retiring instructions
        for (int i = 0; i < CMAX + 10; i++)
            issue(1, 0, 1, 1, 0, 2'b11, 2'd0, 0, i, 5'd1);
        check("sat_cnt", o_retired_count, cexp(CMAX));

        async_reset("rst_mid");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                i_halt = 0;
                async_reset("rst_rand");
            end else begin
                rand_issue();
            end
        end
        i_halt = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
